// File: rtl/count_seq_pkg.sv
// Shared constants for the count sequencer: FSM encodings, data width, requester count.
package count_seq_pkg;
  localparam int DATA_W  = 8;
  localparam int NUM_REQ = 2;

  typedef logic [DATA_W-1:0] data_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_COUNT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;
endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; the pointer names the requester that wins a tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic       gnt_sel
);
  logic ptr, last;

  assign gnt_sel = req[ptr] ? ptr : ~ptr;

  // The requester picked at grant is remembered so advance can hand priority to the other one.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr  <= 1'b0;
      last <= 1'b0;
    end else begin
      if (|req)   last <= gnt_sel;
      if (advance) ptr <= ~last;
    end
  end
endmodule

// File: rtl/count_seq_ctrl.sv
// Sequencer that grants a shared external up-counter to one of two requesters per run.
// Optional abort input/aborted output are built when COUNT_SEQ_ABORT_EN is defined.
module count_seq_ctrl
  import count_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic [7:0] ini0,
  input  logic [7:0] ini1,
  input  logic [7:0] fin0,
  input  logic [7:0] fin1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic [7:0] entrada,
  output logic       load,
  output logic       countUp,
  input  logic [7:0] REz
`ifdef COUNT_SEQ_ABORT_EN
  ,
  input  logic       abort,
  output logic       aborted
`endif
);
  logic [1:0]         state_q;
  logic               owner_q;
  data_t              ini_q, fin_q;
  logic [NUM_REQ-1:0] arb_req;
  logic               gnt_sel, advance, abort_hit, busy;

  // Only IDLE arbitrates, so the arbiter sees requests solely when a grant can happen.
  assign arb_req = (state_q == ST_IDLE) ? {req1, req0} : '0;

`ifdef COUNT_SEQ_ABORT_EN
  logic aborted_q;
  assign abort_hit = abort && ((state_q == ST_LOAD) || (state_q == ST_COUNT));
  assign aborted   = aborted_q;

  always_ff @(posedge clk) begin
    if (rst) aborted_q <= 1'b0;
    else     aborted_q <= abort_hit;
  end
`else
  assign abort_hit = 1'b0;
`endif

  assign advance = (state_q == ST_DONE) || abort_hit;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (arb_req),
    .advance (advance),
    .gnt_sel (gnt_sel)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      ini_q   <= '0;
      fin_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (|arb_req) begin
          state_q <= ST_LOAD;
          owner_q <= gnt_sel;
          ini_q   <= gnt_sel ? ini1 : ini0;
          fin_q   <= gnt_sel ? fin1 : fin0;
        end
        ST_LOAD:  state_q <= ST_COUNT;
        ST_COUNT: if (REz == fin_q) state_q <= ST_DONE;
        default:  state_q <= ST_IDLE;
      endcase
      if (abort_hit) state_q <= ST_IDLE;
    end
  end

  assign busy    = (state_q != ST_IDLE);
  assign gnt0    = busy && !owner_q;
  assign gnt1    = busy &&  owner_q;
  assign done0   = (state_q == ST_DONE) && !owner_q;
  assign done1   = (state_q == ST_DONE) &&  owner_q;
  assign load    = (state_q == ST_LOAD);
  assign entrada = load ? ini_q : 8'h00;
  // Stepping stops on the cycle REz already equals the target, so ini==fin gives no increments.
  assign countUp = (state_q == ST_COUNT) && (REz != fin_q);
endmodule

// File: tb/tb_count_seq_ctrl.sv
// Directed bench for count_seq_ctrl with a behavioural counter (countUp beats load).
// Abort checks are compiled in when COUNT_SEQ_ABORT_EN is defined.
module tb_count_seq_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] ini0 = '0, ini1 = '0, fin0 = '0, fin1 = '0;
  logic       gnt0, gnt1, done0, done1, load, countUp;
  logic [7:0] entrada;
  logic [7:0] rez = '0;
`ifdef COUNT_SEQ_ABORT_EN
  logic       abort = 1'b0;
  logic       aborted;
`endif
  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (countUp)   rez <= rez + 8'd1;
    else if (load) rez <= entrada;
  end

  count_seq_ctrl dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1),
    .ini0(ini0), .ini1(ini1), .fin0(fin0), .fin1(fin1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .entrada(entrada), .load(load), .countUp(countUp), .REz(rez)
`ifdef COUNT_SEQ_ABORT_EN
    , .abort(abort), .aborted(aborted)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic logic [5:0] outs();
    return {gnt0, gnt1, done0, done1, load, countUp};
  endfunction

  // One isolated run for requester r; counts latency, strobes and overlap until its done.
  task automatic do_run(input string tag, input bit r, input logic [7:0] i, input logic [7:0] f,
                        input int exp_n);
    int cyc = 0, ups = 0, lds = 0, ovl = 0;
    bit seen = 0;
    if (r) begin req1 = 1; ini1 = i; fin1 = f; end
    else   begin req0 = 1; ini0 = i; fin0 = f; end
    while (!seen && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (load) begin
        lds++;
        chk({tag, "_entrada"}, entrada, i);
        chk({tag, "_gnt_load"}, r ? gnt1 : gnt0, 1);
        // Post-grant changes must not disturb the latched run.
        if (r) begin ini1 = ~i; fin1 = ~f; end
        else   begin ini0 = ~i; fin0 = ~f; end
      end
      if (countUp) ups++;
      if (load && countUp) ovl++;
      if (!load) chk({tag, "_entrada_idle"}, entrada, 0);
      seen = r ? done1 : done0;
    end
    chk({tag, "_seen_done"}, seen, 1);
    chk({tag, "_latency"}, cyc, 3 + exp_n);
    chk({tag, "_ups"}, ups, exp_n);
    chk({tag, "_loads"}, lds, 1);
    chk({tag, "_overlap"}, ovl, 0);
    chk({tag, "_rez"}, rez, f);
    chk({tag, "_gnt_done"}, r ? gnt1 : gnt0, 1);
    if (r) req1 = 0; else req0 = 0;
    @(negedge clk);
    chk({tag, "_idle_outs"}, outs(), 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_outs", outs(), 0);
    chk("reset_entrada", entrada, 0);
    rst = 0;
    @(negedge clk);
    chk("idle_outs", outs(), 0);

    do_run("single", 0, 8'd10, 8'd13, 3);
    do_run("wrap",   1, 8'd254, 8'd1, 3);
    do_run("zero",   0, 8'd77, 8'd77, 0);

    // Contention: both requesters held high out of reset must alternate 0,1,0,1.
    rst = 1;
    ini0 = 8'd0; fin0 = 8'd2; ini1 = 8'd5; fin1 = 8'd6;
    req0 = 1; req1 = 1;
    @(negedge clk);
    rst = 0;
    for (int k = 0; k < 4; k++) begin
      int cyc = 0;
      while (!(done0 || done1) && cyc < 100) begin
        @(negedge clk);
        cyc++;
        chk($sformatf("cont%0d_onehot", k), gnt0 && gnt1, 0);
      end
      chk($sformatf("cont%0d_done1", k), done1, k % 2);
      chk($sformatf("cont%0d_done0", k), done0, (k + 1) % 2);
      chk($sformatf("cont%0d_gnt_owner", k), gnt1, k % 2);
      if (k == 3) begin req0 = 0; req1 = 0; end
      @(negedge clk);
    end
    chk("cont_idle", outs(), 0);

    // Reset during the second countUp cycle.
    begin
      int ups = 0, cyc = 0;
      req0 = 1; ini0 = 8'd0; fin0 = 8'd50;
      while (ups < 2 && cyc < 100) begin
        @(negedge clk);
        cyc++;
        if (countUp) ups++;
      end
      chk("midrst_reached", ups, 2);
      rst = 1;
      @(negedge clk);
      chk("midrst_outs", outs(), 0);
      chk("midrst_entrada", entrada, 0);
      rst = 0; req0 = 0;
      @(negedge clk);
      chk("midrst_stays_idle", outs(), 0);
    end

`ifdef COUNT_SEQ_ABORT_EN
    begin
      int ups = 0, cyc = 0;
      req0 = 1; req1 = 1; ini0 = 8'd0; fin0 = 8'd50; ini1 = 8'd3; fin1 = 8'd4;
      while (ups < 2 && cyc < 100) begin
        @(negedge clk);
        cyc++;
        if (countUp) ups++;
      end
      chk("abort_owner0", gnt0, 1);
      abort = 1;
      @(negedge clk);
      abort = 0;
      chk("abort_pulse", aborted, 1);
      chk("abort_outs", outs(), 0);
      @(negedge clk);
      chk("abort_pulse_end", aborted, 0);
      chk("abort_next_gnt1", gnt1, 1);
      chk("abort_next_load", load, 1);
      req0 = 0;
      cyc = 0;
      while (!done1 && cyc < 100) begin
        @(negedge clk);
        cyc++;
      end
      chk("abort_done1", done1, 1);
      req1 = 0;
      @(negedge clk);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
